// File: rtl/load_store_unit.sv
// Word-wide data-memory initiator: sub-word loads with extension, sub-word stores by read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned h/w accesses with resp_err instead of truncating the address.
//
// state   | meaning
// IDLE    | ready for a request; memory port idle
// RADDR   | read address presented to memory
// RDATA   | read word on mem_dout; extend (load) or merge (sub-word store)
// WRITE   | write word presented to memory (mem_we=1)
// WCOMMIT | write committing (or misaligned trap); response issued on exit

module load_store_unit #(
   parameter int ADDRW = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WCOMMIT} state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   state_t             state;
   logic               we_q;
   logic [1:0]         size_q;
   logic               sign_q;
   logic               err_q;
   logic [ADDRW-1:0]   addr_q;
   logic [31:0]        wdata_q;

   logic [1:0]         req_size;
   logic               req_signed;
   logic               req_misalign;
   logic [31:0]        req_word_addr;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [31:0]        load_ext;
   logic [31:0]        merged;
   logic               unused_addr_hi;

   assign req_ready      = (state == IDLE) && !rst;
   assign req_word_addr  = {{(32-ADDRW){1'b0}}, req_addr[ADDRW-1:2], 2'b00};
   assign unused_addr_hi = ^req_addr[31:ADDRW];

   // Unsigned widths on a store and undefined codes fall back to a word access.
   always_comb begin
      req_size   = SZ_W;
      req_signed = 1'b0;
      case (req_funct3)
         3'b000: begin
            req_size   = SZ_B;
            req_signed = 1'b1;
         end
         3'b001: begin
            req_size   = SZ_H;
            req_signed = 1'b1;
         end
         3'b100: if (!req_we) req_size = SZ_B;
         3'b101: if (!req_we) req_size = SZ_H;
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   assign req_misalign = ((req_size == SZ_H) && req_addr[0]) ||
                         ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
   assign req_misalign = 1'b0;
`endif

   // Little-endian lane pick; halfword lane ignores addr[0], so odd halfwords truncate to even.
   always_comb begin
      byte_sel = mem_dout[{addr_q[1:0], 3'b000} +: 8];
      half_sel = mem_dout[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_B:    load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
         SZ_H:    load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
         default: load_ext = mem_dout;
      endcase
      merged = mem_dout;
      case (size_q)
         SZ_B:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         SZ_H:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         we_q       <= 1'b0;
         size_q     <= SZ_W;
         sign_q     <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
      end else begin
         case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid && req_ready) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  sign_q  <= req_signed;
                  err_q   <= req_misalign;
                  addr_q  <= req_addr[ADDRW-1:0];
                  wdata_q <= req_wdata;
                  if (req_misalign) begin
                     state <= WCOMMIT;
                  end else if (req_we && (req_size == SZ_W)) begin
                     state    <= WRITE;
                     mem_we   <= 1'b1;
                     mem_addr <= req_word_addr;
                     mem_din  <= req_wdata;
                  end else begin
                     state    <= RADDR;
                     mem_addr <= req_word_addr;
                  end
               end
            end
            RADDR: state <= RDATA;
            RDATA: begin
               if (!we_q) begin
                  resp_rdata <= load_ext;
                  resp_err   <= 1'b0;
                  resp_valid <= 1'b1;
                  mem_addr   <= '0;
                  state      <= IDLE;
               end else begin
                  mem_we  <= 1'b1;
                  mem_din <= merged;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               mem_we  <= 1'b0;
               mem_din <= '0;
               state   <= WCOMMIT;
            end
            WCOMMIT: begin
               resp_rdata <= '0;
               resp_err   <= err_q;
               resp_valid <= 1'b1;
               mem_addr   <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the core's word-wide data-memory port. Accepts one load or store request at a time from the execute stage over a valid/ready handshake, and issues the word-granular read/write sequence the data memory requires. Sign/zero-extends byte and halfword loads, and implements byte/halfword stores as read-modify-write because the memory only writes full words. Returns one response pulse per request to the writeback stage.

## Interface
Parameters:
- `ADDRW`, 10: number of low `req_addr` bits forwarded to memory; bits above are driven 0 on `mem_addr`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; `(state==IDLE) && !rst`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; byte/halfword taken from LSBs.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_err`  out  1  misaligned access flag, valid with `resp_valid`.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  word-aligned address, bits [1:0] always 0.
- `mem_din`  out  32  memory write data.
- `mem_dout`  in  32  memory read data, valid the cycle after the address is sampled.

## Operation
- Memory contract:
  - The memory samples `mem_addr`, `mem_we` and `mem_din` at every edge.
  - Read data appears on `mem_dout` in the following cycle.
  - A sampled write commits at the next edge after sampling.
- Handshake:
  - Request is accepted at an edge where `req_valid && req_ready`.
  - All request fields are registered at acceptance.
  - Request inputs are ignored outside IDLE.
- FSM states: IDLE, RADDR, RDATA, WRITE, WCOMMIT.
  - IDLE → RADDR: load, or byte/halfword store.
  - IDLE → WRITE: word store.
  - RADDR → RDATA: always.
  - RDATA → IDLE (load): registers extended data and pulses `resp_valid`.
  - RDATA → WRITE (sub-word store): registers the merged word.
  - WRITE → WCOMMIT: always.
  - WCOMMIT → IDLE: pulses `resp_valid`.
- Memory-port drive by state:
  - `mem_we` is 1 only in WRITE.
  - `mem_addr` = `{req_addr_q[ADDRW-1:2], 2'b00}` zero-extended in every non-IDLE state; 0 in IDLE.
  - `mem_din` holds the write word in WRITE; 0 otherwise.
- Lane selection is little-endian:
  - Byte lane = `addr[1:0]`.
  - Halfword lane = `addr[1]`.
- Loads:
  - b / h: sign-extend the selected lane.
  - bu / hu: zero-extend the selected lane.
  - w: pass the word through.
- Sub-word stores: replace only the selected lane(s) of `mem_dout` with `req_wdata` LSBs; all other bytes are preserved.
- Undefined funct3 codes, and bu/hu codes on a store, are handled as a word access.

## Timing
- Outputs in reset: `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, state=IDLE. Asserting `rst` forces these immediately.
- Latencies, with acceptance at edge k:
  - Load: `resp_valid` high in the cycle after edge k+2.
  - Word store: `resp_valid` high in the cycle after edge k+2; memory is already written at that point.
  - Sub-word store: `resp_valid` high in the cycle after edge k+4.
- `req_ready` is high in the `resp_valid` cycle, so back-to-back issue gives a load throughput of 1 per 3 cycles.
- A load issued immediately after a store's response reads the stored value, because the write committed before the response.
- Reset mid-operation abandons the request, and no response is produced. A write already sampled by the memory in WRITE may still commit.
- `resp_rdata` and `resp_err` hold their values until the next response.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are h/hu with `addr[0]`=1, and w with `addr[1:0]`≠0.
  - They perform no memory access at all (`mem_we` stays 0).
  - They go IDLE → WCOMMIT → IDLE with `resp_err`=1 and `resp_rdata`=0.
- Not defined: `addr` low bits are truncated (halfword forced to even, word to aligned), and `resp_err` is tied 0.

## Test plan
- After reset, sw addr 0x10 data 0xDEADBEEF, then lw 0x10 → `resp_rdata`=0xDEADBEEF; `mem_we` high for exactly one cycle.
- Memory word 0x80 = 0x11223344; lb 0x83 → 0x00000011; lbu 0x80 → 0x00000044; lh 0x82 → 0x00001122.
- Memory word 0x20 = 0x000080FF; lb 0x20 → 0xFFFFFFFF; lh 0x20 → 0xFFFF80FF; lhu 0x20 → 0x000080FF.
- Memory word 0x40 = 0xAABBCCDD; sb 0x41 data 0x12 → word 0xAABB12DD; sh 0x42 data 0x5678 → 0x567812DD; response 4 cycles after acceptance.
- `rst` asserted during WRITE of a sub-word store → all outputs 0 immediately, no `resp_valid`; after release, `req_ready`=1.
- With `LSU_MISALIGN_TRAP_EN`: lw 0x41 → `resp_err`=1, `resp_rdata`=0, no memory write; without it: lw 0x41 returns word 0x40.
